// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART unit and its serialisers.
package uart_pkg;

  // Clocks per serial bit, shared by transmitter and receiver.
  localparam int BAUD_DIV = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {IDLE, SEND_PUSH, RECV_WAIT, RECV_POP, DONE} cmd_state_t;
  typedef enum logic [1:0] {TD_IDLE, TD_START, TD_ARM, TD_WAIT} td_state_t;

  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with first-word-fall-through output; push while full is honoured when a pop happens too.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 deserialiser with mid-bit sampling; ready pulses once per frame, ferr flags a low stop bit.
module uart_rx
  import uart_pkg::*;
(
  output byte_t rdata,
  output logic  ready,
  output logic  ferr,
  input  logic  rxd,
  input  logic  clk,
  input  logic  rstn
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int DW = $clog2(BAUD_DIV);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  byte_t         shreg;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Frames begin on a falling edge, so a line left low by a bad stop bit is not mistaken for a start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= RX_IDLE;
      rdata   <= '0;
      ready   <= 1'b0;
      ferr    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        RX_IDLE: begin
          div_cnt <= '0;
          if (rx_prev && !rx_s) state <= RX_START;
        end
        RX_START: begin
          if (div_cnt == DW'(BAUD_DIV/2 - 1)) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (div_cnt == DW'(BAUD_DIV-1)) begin
            div_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= RX_STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (div_cnt == DW'(BAUD_DIV-1)) begin
            rdata <= shreg;
            ferr  <= !rx_s;
            ready <= 1'b1;
            state <= RX_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serialiser: start latches a byte, busy rises the following cycle and drops after the stop bit.
module uart_tx
  import uart_pkg::*;
(
  input  byte_t data,
  input  logic  start,
  output logic  busy,
  output logic  txd,
  input  logic  clk,
  input  logic  rstn
);

  localparam int DW = $clog2(BAUD_DIV);

  logic [8:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy    <= 1'b0;
      txd     <= 1'b1;
      shreg   <= '1;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (!busy) begin
      if (start) begin
        shreg   <= {1'b1, data};
        txd     <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= '0;
        div_cnt <= '0;
      end
    end else if (div_cnt == DW'(BAUD_DIV-1)) begin
      div_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        busy <= 1'b0;
      end else begin
        txd     <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_buffered_unit.sv
// Buffered UART control unit: byte FIFOs in both directions, one go/done per DATA_W/8-byte word.
// Defining UART_LOOPBACK_EN adds lb_en, which loops the transmitter into the receiver and parks txd high.
module uart_buffered_unit
  import uart_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              go,
  input  logic              rors,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              rx_overrun,
  output logic              rx_ferr,
  output logic              txd,
`ifdef UART_LOOPBACK_EN
  input  logic              lb_en,
`endif
  input  logic              rxd
);

  localparam int NB  = nbytes(DATA_W);
  localparam int KW  = $clog2(NB) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;

  cmd_state_t        cmd_state;
  td_state_t         td_state;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] rx_next;
  logic [KW-1:0]     k;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  byte_t             tx_dout, tx_byte;
  logic [TCW-1:0]    unused_tx_count;
  logic              tx_start, tx_busy, tx_line;

  logic              rx_push, rx_pop, rx_full, unused_rx_empty;
  byte_t             rx_dout, rx_byte;
  logic [RCW-1:0]    rx_count;
  logic              rx_ready, rx_bad, rx_line;

`ifdef UART_LOOPBACK_EN
  assign rx_line = lb_en ? tx_line : rxd;
  assign txd     = lb_en ? 1'b1 : tx_line;
`else
  assign rx_line = rxd;
  assign txd     = tx_line;
`endif

  uart_tx u_tx (
    .data (tx_byte),
    .start(tx_start),
    .busy (tx_busy),
    .txd  (tx_line),
    .clk  (clk),
    .rstn (rstn)
  );

  uart_rx u_rx (
    .rdata(rx_byte),
    .ready(rx_ready),
    .ferr (rx_bad),
    .rxd  (rx_line),
    .clk  (clk),
    .rstn (rstn)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (tx_push),
    .pop  (tx_pop),
    .din  (wdata_q[7:0]),
    .dout (tx_dout),
    .full (tx_full),
    .empty(tx_empty),
    .count(unused_tx_count)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (rx_push),
    .pop  (rx_pop),
    .din  (rx_byte),
    .dout (rx_dout),
    .full (rx_full),
    .empty(unused_rx_empty),
    .count(rx_count)
  );

  assign rx_push = rx_ready && !rx_bad;
  assign rx_pop  = (cmd_state == RECV_POP);
  assign tx_push = (cmd_state == SEND_PUSH) && !tx_full;
  assign tx_pop  = (td_state == TD_IDLE) && !tx_empty && !tx_busy;
  assign rx_next = (rx_word >> 8) | (DATA_W'(rx_dout) << (DATA_W - 8));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_overrun <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
      if (rx_ready && rx_bad)            rx_ferr    <= 1'b1;
    end
  end

  // Busy from the serialiser lags start by a cycle, hence the TD_ARM guard before trusting it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      td_state <= TD_IDLE;
      tx_start <= 1'b0;
      tx_byte  <= '0;
    end else begin
      case (td_state)
        TD_IDLE: begin
          if (tx_pop) begin
            tx_byte  <= tx_dout;
            tx_start <= 1'b1;
            td_state <= TD_START;
          end
        end
        TD_START: begin
          tx_start <= 1'b0;
          td_state <= TD_ARM;
        end
        TD_ARM:  td_state <= TD_WAIT;
        TD_WAIT: if (!tx_busy) td_state <= TD_IDLE;
        default: td_state <= TD_IDLE;
      endcase
    end
  end

  // Words go out LSB byte first and are reassembled the same way, so byte 0 always lands in bits 7:0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_state <= IDLE;
      done      <= 1'b0;
      rdata     <= '0;
      wdata_q   <= '0;
      rx_word   <= '0;
      k         <= '0;
    end else begin
      done <= 1'b0;
      case (cmd_state)
        IDLE: begin
          if (go) begin
            k <= '0;
            if (rors) begin
              wdata_q   <= wdata;
              cmd_state <= SEND_PUSH;
            end else begin
              cmd_state <= RECV_WAIT;
            end
          end
        end
        SEND_PUSH: begin
          if (!tx_full) begin
            wdata_q <= wdata_q >> 8;
            k       <= k + 1'b1;
            if (k == KW'(NB - 1)) begin
              done      <= 1'b1;
              cmd_state <= DONE;
            end
          end
        end
        RECV_WAIT: if (rx_count >= RCW'(NB)) cmd_state <= RECV_POP;
        RECV_POP: begin
          rx_word <= rx_next;
          k       <= k + 1'b1;
          if (k == KW'(NB - 1)) begin
            rdata     <= rx_next;
            done      <= 1'b1;
            cmd_state <= DONE;
          end
        end
        DONE:    cmd_state <= IDLE;
        default: cmd_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_buffered_unit.sv
// Bench for uart_buffered_unit: drives serial bytes on rxd, decodes txd, and scores words and bytes from queues.
`timescale 1ns/1ps
module tb_uart_buffered_unit;
  import uart_pkg::*;

  localparam int DATA_W   = 32;
  localparam int RX_DEPTH = 4;
  localparam int TX_DEPTH = 16;
  localparam int NB       = DATA_W / 8;

  typedef struct {
    bit          recv;
    logic [31:0] word;
  } done_exp_t;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        go   = 1'b0;
  logic        rors = 1'b0;
  logic        rxd  = 1'b1;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done, rx_overrun, rx_ferr, txd;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  done_exp_t   done_q[$];
  byte_t       tx_q[$];

  always #5 clk = ~clk;

  uart_buffered_unit #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
`ifdef UART_LOOPBACK_EN
    .lb_en     (1'b0),
`endif
    .clk       (clk),
    .rstn      (rstn),
    .go        (go),
    .rors      (rors),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .rx_overrun(rx_overrun),
    .rx_ferr   (rx_ferr),
    .txd       (txd),
    .rxd       (rxd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic driveRxByte(input byte_t b, input bit bad_stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    rxd = bad_stop ? 1'b0 : 1'b1;
    repeat (BAUD_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BAUD_DIV) @(negedge clk);
  endtask

  // exp_lat of 0 issues the command without waiting for completion.
  task automatic applyStimulus(input bit send, input logic [31:0] word, input int exp_lat);
    done_exp_t e;
    int        lat;
    @(negedge clk);
    go    = 1'b1;
    rors  = send;
    wdata = send ? word : $urandom;
    e.recv = !send;
    e.word = word;
    done_q.push_back(e);
    if (send) for (int i = 0; i < NB; i++) tx_q.push_back(word[8*i +: 8]);
    if (exp_lat > 0) begin
      lat = 0;
      do begin
        @(negedge clk);
        go = 1'b0;
        lat++;
      end while (!done && lat < 50);
      checkOutput("done_latency", 32'(lat), 32'(exp_lat));
      @(negedge clk);
      checkOutput("done_single_pulse", 32'(done), 32'd0);
    end else begin
      @(negedge clk);
      go = 1'b0;
    end
  endtask

  task automatic waitDoneCount(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic waitTxDrain(input int budget);
    int n = 0;
    while (tx_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_drained", 32'(tx_q.size()), 32'd0);
  endtask

  // Every done pulse must match a queued command; receives also carry the expected word.
  initial begin
    done_exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        checkOutput("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          e = done_q.pop_front();
          if (e.recv) checkOutput("rdata", rdata, e.word);
        end
      end
    end
  end

  initial begin
    byte_t b;
    logic  stop_bit;
    forever begin
      @(negedge clk);
      if (rstn && txd === 1'b0) begin
        repeat (BAUD_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD_DIV) @(negedge clk);
          b[i] = txd;
        end
        repeat (BAUD_DIV) @(negedge clk);
        stop_bit = txd;
        checkOutput("tx_stop_bit", 32'(stop_bit), 32'd1);
        checkOutput("tx_byte_expected", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) checkOutput("tx_byte", 32'(b), 32'(tx_q.pop_front()));
      end
    end
  end

  initial begin
    int base;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_overrun", 32'(rx_overrun), 32'd0);
    checkOutput("reset_ferr", 32'(rx_ferr), 32'd0);
    checkOutput("reset_txd", 32'(txd), 32'd1);
    rstn = 1'b1;

    driveRxByte(8'h11, 1'b0);
    driveRxByte(8'h22, 1'b0);
    driveRxByte(8'h33, 1'b0);
    driveRxByte(8'h44, 1'b0);
    applyStimulus(1'b0, 32'h44332211, NB + 2);

    applyStimulus(1'b1, 32'hA1B2C3D4, NB + 1);
    waitTxDrain(3000);

    base = done_cnt;
    applyStimulus(1'b0, 32'hC33CA55A, 0);
    driveRxByte(8'h5A, 1'b0);
    driveRxByte(8'hA5, 1'b0);
    driveRxByte(8'h3C, 1'b0);
    checkOutput("recv_wait_no_done", 32'(done_cnt), 32'(base));
    driveRxByte(8'hC3, 1'b0);
    waitDoneCount(base + 1, 200);

    checkOutput("overrun_clear", 32'(rx_overrun), 32'd0);
    driveRxByte(8'h55, 1'b0);
    driveRxByte(8'h66, 1'b0);
    driveRxByte(8'h77, 1'b0);
    driveRxByte(8'h88, 1'b0);
    driveRxByte(8'h99, 1'b0);
    checkOutput("overrun_set", 32'(rx_overrun), 32'd1);
    applyStimulus(1'b0, 32'h88776655, NB + 2);

    checkOutput("ferr_clear", 32'(rx_ferr), 32'd0);
    driveRxByte(8'hAA, 1'b1);
    checkOutput("ferr_set", 32'(rx_ferr), 32'd1);
    driveRxByte(8'h01, 1'b0);
    driveRxByte(8'h02, 1'b0);
    driveRxByte(8'h03, 1'b0);
    driveRxByte(8'h04, 1'b0);
    applyStimulus(1'b0, 32'h04030201, NB + 2);
    checkOutput("overrun_sticky", 32'(rx_overrun), 32'd1);

    // Leave two bytes queued, then reset in the middle of a send.
    driveRxByte(8'hEE, 1'b0);
    driveRxByte(8'hFF, 1'b0);
    @(negedge clk);
    go    = 1'b1;
    rors  = 1'b1;
    wdata = 32'hDEADBEEF;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_txd", 32'(txd), 32'd1);
    checkOutput("midreset_rdata", rdata, 32'd0);
    checkOutput("midreset_overrun", 32'(rx_overrun), 32'd0);
    checkOutput("midreset_ferr", 32'(rx_ferr), 32'd0);
    repeat (3 * BAUD_DIV) @(negedge clk);
    checkOutput("txd_idle_after_reset", 32'(txd), 32'd1);

    applyStimulus(1'b1, 32'h5A6B7C8D, NB + 1);
    driveRxByte(8'h10, 1'b0);
    driveRxByte(8'h20, 1'b0);
    driveRxByte(8'h30, 1'b0);
    driveRxByte(8'h40, 1'b0);
    applyStimulus(1'b0, 32'h40302010, NB + 2);
    waitTxDrain(3000);
    checkOutput("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
